// File: rtl/fm_readback_streamer_if.sv
// fm_readback_streamer_if: byte stream carrying pixels with first-of-channel and end-of-transfer flags
interface fm_readback_streamer_if;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tuser;
  logic       m_tlast;
  modport master (output m_tdata, m_tvalid, m_tuser, m_tlast, input m_tready);
  modport slave  (input m_tdata, m_tvalid, m_tuser, m_tlast, output m_tready);
endinterface

// File: rtl/fm_readback_streamer.sv
// fm_readback_streamer: walks a channel/pixel range on the accelerator readback port, absorbs the
// fixed read latency and streams the pixels out with full backpressure
module fm_readback_streamer #(
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CH     = 112
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [6:0]  cmd_ch_base,
  input  logic [6:0]  cmd_ch_count,
  input  logic [12:0] cmd_pix_count,
  input  logic        acc_busy,
  output logic [6:0]  output_ch,
  output logic [11:0] output_addr,
  input  logic [7:0]  output_data,
  fm_readback_streamer_if.master m,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + READ_LAT + 1);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [6:0] ch_q, ch_end_q;
  logic [11:0] addr_q;
  logic [12:0] pix_q;
  logic err_q;
  logic [READ_LAT-1:0] tv_q, tf_q, tl_q;
  logic [9:0] mem_q [FIFO_DEPTH];
  ptr_t wp_q, rp_q;
  cnt_t cnt_q, inflight;
  logic cmd_ok, issue, flush, accept, reject, ch_end, pix_end, wr, rd, credit;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) inflight = inflight + cnt_t'(tv_q[i]);
  end
  // Reads already in flight reserve a FIFO slot, so the FIFO can never overflow
  assign credit = cnt_q + inflight < cnt_t'(FIFO_DEPTH);
  assign pix_end = {1'b0, addr_q} + 13'd1 == pix_q;
  assign ch_end = ch_q == ch_end_q;
  assign cmd_ok = !acc_busy && cmd_ch_count != '0 && cmd_pix_count != '0 && cmd_pix_count <= 13'd4096 &&
                  {1'b0, cmd_ch_base} + {1'b0, cmd_ch_count} <= 8'(NUM_CH);
  assign wr = tv_q[READ_LAT-1];
  assign rd = m.m_tvalid && m.m_tready;
  assign m.m_tvalid = cnt_q != '0;
  assign {m.m_tlast, m.m_tuser, m.m_tdata} = mem_q[rp_q];
  assign output_ch = ch_q;
  assign output_addr = addr_q;
  assign busy = state_q == ISSUE || state_q == DRAIN;
  assign done = state_q == DONE;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    issue = 1'b0;
    flush = 1'b0;
    accept = 1'b0;
    reject = 1'b0;
    case (state_q)
      IDLE: begin
        accept = cmd_start && cmd_ok;
        reject = cmd_start && !cmd_ok;
        state_d = accept ? ISSUE : IDLE;
      end
      ISSUE: begin
        flush = acc_busy;
        issue = !acc_busy && credit;
        state_d = acc_busy ? IDLE : (issue && ch_end && pix_end) ? DRAIN : ISSUE;
      end
      DRAIN: begin
        flush = acc_busy;
        state_d = acc_busy ? IDLE :
                  (inflight == '0 && (cnt_q == '0 || (cnt_q == cnt_t'(1) && rd))) ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q <= '0;
      ch_end_q <= '0;
      addr_q <= '0;
      pix_q <= '0;
      err_q <= 1'b0;
      tv_q <= '0;
      tf_q <= '0;
      tl_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      err_q <= accept ? 1'b0 : (reject || flush) ? 1'b1 : err_q;
      if (accept) begin
        ch_q <= cmd_ch_base;
        addr_q <= '0;
        ch_end_q <= cmd_ch_base + cmd_ch_count - 7'd1;
        pix_q <= cmd_pix_count;
      end else if (issue && !(ch_end && pix_end)) begin
        addr_q <= pix_end ? '0 : addr_q + 12'd1;
        ch_q <= pix_end ? ch_q + 7'd1 : ch_q;
      end
      if (flush) begin
        tv_q <= '0;
        tf_q <= '0;
        tl_q <= '0;
        wp_q <= '0;
        rp_q <= '0;
        cnt_q <= '0;
      end else begin
        tv_q <= READ_LAT'({tv_q, issue});
        tf_q <= READ_LAT'({tf_q, addr_q == '0});
        tl_q <= READ_LAT'({tl_q, ch_end && pix_end});
        if (wr) mem_q[wp_q] <= {tl_q[READ_LAT-1], tf_q[READ_LAT-1], output_data};
        wp_q <= !wr ? wp_q : (wp_q == ptr_t'(FIFO_DEPTH - 1)) ? '0 : wp_q + 1'b1;
        rp_q <= !rd ? rp_q : (rp_q == ptr_t'(FIFO_DEPTH - 1)) ? '0 : rp_q + 1'b1;
        cnt_q <= cnt_q + cnt_t'(wr) - cnt_t'(rd);
      end
    end
  end
endmodule
